// File: rtl/fp_sqrt_pkg.sv
// fp_sqrt_pkg
//   Shared constants, FSM state type and the special-operand decoder used by
//   the iterative single-precision square-root unit (fp_sqrt) and its
//   integer-root datapath (isqrt_core).
package fp_sqrt_pkg;

    localparam int          BIAS   = 127;
    localparam logic [31:0] QNAN   = 32'h7FC0_0000;
    localparam logic [31:0] PINF   = 32'h7F80_0000;
    localparam int          ITER   = 25;   // one root bit per iteration
    localparam int          RAD_W  = 50;   // radicand width, two bits consumed per iteration
    localparam int          ROOT_W = 25;   // 1 hidden + 23 fraction + 1 guard

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CALC = 2'd2,
        RND  = 2'd3
    } state_e;

    typedef struct packed {
        logic        hit;    // operand bypasses the iterative datapath
        logic [31:0] value;  // final result when hit is set
    } special_t;

    // Classify an operand. Zero/subnormal is tested before the sign so that
    // -0 and negative subnormals come back as -0 rather than NaN.
    function automatic special_t decode_special(input logic [31:0] op);
        special_t r;
        r.hit   = 1'b1;
        r.value = QNAN;
        if ((op[30:23] == 8'hFF) && (op[22:0] != 23'd0)) begin
            r.value = QNAN;
        end else if (op[30:23] == 8'h00) begin
            r.value = {op[31], 31'd0};
        end else if (op[31] == 1'b1) begin
            r.value = QNAN;
        end else if (op[30:23] == 8'hFF) begin
            r.value = PINF;
        end else begin
            r.hit   = 1'b0;
            r.value = 32'd0;
        end
        return r;
    endfunction

endpackage

// File: rtl/isqrt_core.sv
// isqrt_core
//   Restoring digit-recurrence integer square root, one root bit per clock.
//   init loads a new radicand and starts ITER iterations; busy stays high
//   until the last iteration has been taken, after which root holds
//   floor(sqrt(radicand)).
// Ports
//   clk       in   rising-edge clock
//   rst       in   asynchronous active-high reset
//   init      in   load radicand and (re)start the recurrence
//   radicand  in   RAD_W-bit unsigned operand
//   root      out  ROOT_W-bit integer root
//   busy      out  high while iterations remain
module isqrt_core
    import fp_sqrt_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              init,
    input  logic [RAD_W-1:0]  radicand,
    output logic [ROOT_W-1:0] root,
    output logic              busy
);

    logic [RAD_W-1:0]  rad_q;
    logic [ROOT_W:0]   rem_q;    // partial remainder never exceeds 2*root
    logic [ROOT_W-1:0] root_q;
    logic [4:0]        cnt_q;
    logic              busy_q;

    logic [ROOT_W+2:0] trial_s;
    logic [ROOT_W+2:0] sub_s;
    logic              take_s;
    logic [ROOT_W:0]   diff_s;

    // Trial subtraction of {root, 01} from the remainder extended by the next radicand pair.
    always_comb begin
        trial_s = {rem_q, rad_q[RAD_W-1 -: 2]};
        sub_s   = {1'b0, root_q, 2'b01};
        take_s  = (trial_s >= sub_s);
        // The true difference fits in the remainder width when taken, so a
        // narrow modular subtraction gives the exact low bits.
        diff_s  = trial_s[ROOT_W:0] - sub_s[ROOT_W:0];
    end

    // Recurrence state: load on init, otherwise advance one bit while busy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rad_q  <= {RAD_W{1'b0}};
            rem_q  <= {(ROOT_W+1){1'b0}};
            root_q <= {ROOT_W{1'b0}};
            cnt_q  <= 5'd0;
            busy_q <= 1'b0;
        end else if (init) begin
            rad_q  <= radicand;
            rem_q  <= {(ROOT_W+1){1'b0}};
            root_q <= {ROOT_W{1'b0}};
            cnt_q  <= 5'd0;
            busy_q <= 1'b1;
        end else if (busy_q) begin
            rad_q  <= {rad_q[RAD_W-3:0], 2'b00};
            rem_q  <= take_s ? diff_s : trial_s[ROOT_W:0];
            root_q <= {root_q[ROOT_W-2:0], take_s};
            cnt_q  <= cnt_q + 5'd1;
            busy_q <= (cnt_q != 5'(ITER - 1));
        end else begin
            busy_q <= 1'b0;
        end
    end

    assign root = root_q;
    assign busy = busy_q;

endmodule

// File: rtl/fp_sqrt.sv
// fp_sqrt
//   Sequential IEEE-754 binary32 square root with round-to-nearest.
//   start (level) captures data_i; when start falls the operand is decoded,
//   special operands go straight to RND, normal ones run ITER iterations in
//   isqrt_core. RND writes data_o and pulses done for one cycle.
//   start seen in CALC or RND aborts and recaptures.
// Ports
//   clk     in   rising-edge clock
//   rst     in   asynchronous active-high reset
//   start   in   level-sensitive load request
//   data_i  in   operand {sign, exp[7:0], frac[22:0]}
//   data_o  out  registered result, held until the next RND
//   done    out  one-cycle pulse when data_o is updated
module fp_sqrt
    import fp_sqrt_pkg::*;
#(
    parameter int DATAWIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [DATAWIDTH-1:0] data_i,
    output logic [DATAWIDTH-1:0] data_o,
    output logic                 done
);

    state_e      state_q;
    logic [31:0] op_q;
    logic        spec_hit_q;
    logic [31:0] spec_val_q;
    logic [7:0]  exp_q;
    logic [31:0] data_q;
    logic        done_q;

    special_t          spec_s;
    logic [8:0]        exp_sum_s;
    logic [7:0]        res_exp_s;
    logic              odd_s;
    logic [RAD_W-1:0]  rad_s;
    logic              init_s;
    logic [ROOT_W-1:0] root_s;
    logic              core_busy_s;
    logic [24:0]       rnd_s;
    logic [22:0]       frac_s;
    logic [7:0]        out_exp_s;

    // Operand decode and radicand alignment from the captured operand.
    always_comb begin
        spec_s    = decode_special(op_q);
        // (E + 127) >> 1 equals floor((E - 127) / 2) + 127; bit 0 of the sum
        // is set exactly when the unbiased exponent is odd.
        exp_sum_s = {1'b0, op_q[30:23]} + 9'(BIAS);
        res_exp_s = exp_sum_s[8:1];
        odd_s     = exp_sum_s[0];
        // Place 1.frac (or 2*1.frac for odd exponents) with 48 fraction bits.
        if (odd_s) begin
            rad_s = {1'b1, op_q[22:0], 26'd0};
        end else begin
            rad_s = {2'b01, op_q[22:0], 25'd0};
        end
        init_s = (state_q == LOAD) && !start && !spec_s.hit;
    end

    isqrt_core u_core (
        .clk      (clk),
        .rst      (rst),
        .init     (init_s),
        .radicand (rad_s),
        .root     (root_s),
        .busy     (core_busy_s)
    );

    // Round to nearest on the guard bit; a carry out renormalises to 1.0 * 2^(exp+1).
    always_comb begin
        rnd_s = {1'b0, root_s[ROOT_W-1:1]} + {24'd0, root_s[0]};
        if (rnd_s[24]) begin
            frac_s    = rnd_s[23:1];
            out_exp_s = exp_q + 8'd1;
        end else begin
            frac_s    = rnd_s[22:0];
            out_exp_s = exp_q;
        end
    end

    // Control FSM with the operand, special-case and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            op_q       <= 32'd0;
            spec_hit_q <= 1'b0;
            spec_val_q <= 32'd0;
            exp_q      <= 8'd0;
            data_q     <= 32'd0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        op_q    <= data_i;
                        state_q <= LOAD;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                LOAD: begin
                    if (start) begin
                        op_q    <= data_i;
                        state_q <= LOAD;
                    end else if (spec_s.hit) begin
                        spec_hit_q <= 1'b1;
                        spec_val_q <= spec_s.value;
                        state_q    <= RND;
                    end else begin
                        spec_hit_q <= 1'b0;
                        exp_q      <= res_exp_s;
                        state_q    <= CALC;
                    end
                end
                CALC: begin
                    if (start) begin
                        op_q    <= data_i;
                        state_q <= LOAD;
                    end else if (!core_busy_s) begin
                        state_q <= RND;
                    end else begin
                        state_q <= CALC;
                    end
                end
                RND: begin
                    if (start) begin
                        op_q    <= data_i;
                        state_q <= LOAD;
                    end else begin
                        data_q  <= spec_hit_q ? spec_val_q : {1'b0, out_exp_s, frac_s};
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign data_o = data_q;
    assign done   = done_q;

endmodule

// File: tb/tb_fp_sqrt.sv
module tb_fp_sqrt;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] data_i;
    logic [31:0] data_o;
    logic        done;

    int checks;
    int errors;
    int done_cnt;

    fp_sqrt #(.DATAWIDTH(32)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .data_i (data_i),
        .data_o (data_o),
        .done   (done)
    );

    initial clk = 1'b0;
    always #50 clk = ~clk;

    // Count done pulses sampled mid-cycle.
    always @(negedge clk) begin
        if (done === 1'b1) done_cnt = done_cnt + 1;
    end

    // Hold start 150 ns starting just after a rising edge.
    task automatic pulse_start(input logic [31:0] op);
        @(posedge clk);
        #1;
        data_i = op;
        start  = 1'b1;
        #150;
        start  = 1'b0;
    endtask

    task automatic run_case(input string name, input logic [31:0] op, input logic [31:0] exp_val);
        int base;
        base = done_cnt;
        pulse_start(op);
        #5000;
        checks = checks + 1;
        if (data_o !== exp_val) begin
            errors = errors + 1;
            $display("FAIL %s: data_o=%h expected %h", name, data_o, exp_val);
        end
        checks = checks + 1;
        if ((done_cnt - base) !== 1) begin
            errors = errors + 1;
            $display("FAIL %s_done: pulses=%0d expected 1", name, done_cnt - base);
        end
    endtask

    task automatic test_reset;
        rst    = 1'b1;
        start  = 1'b0;
        data_i = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks = checks + 1;
        if (data_o !== 32'd0) begin
            errors = errors + 1;
            $display("FAIL reset_data: data_o=%h expected 00000000", data_o);
        end
        checks = checks + 1;
        if (done !== 1'b0) begin
            errors = errors + 1;
            $display("FAIL reset_done: done=%b expected 0", done);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_normal;
        run_case("sqrt_4",    32'h4080_0000, 32'h4000_0000);
        run_case("sqrt_9",    32'h4110_0000, 32'h4040_0000);
        run_case("sqrt_0p25", 32'h3E80_0000, 32'h3F00_0000);
        run_case("sqrt_2",    32'h4000_0000, 32'h3FB5_04F3);
        run_case("sqrt_1",    32'h3F80_0000, 32'h3F80_0000);
    endtask

    task automatic test_specials;
        run_case("neg_one",   32'hBF80_0000, 32'h7FC0_0000);
        run_case("pos_inf",   32'h7F80_0000, 32'h7F80_0000);
        run_case("neg_zero",  32'h8000_0000, 32'h8000_0000);
        run_case("nan_in",    32'h7FC0_0001, 32'h7FC0_0000);
        run_case("subnormal", 32'h0000_0001, 32'h0000_0000);
    endtask

    task automatic test_reset_mid_calc;
        int base;
        run_case("pre_rst_9", 32'h4110_0000, 32'h4040_0000);
        base = done_cnt;
        pulse_start(32'h4080_0000);
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        checks = checks + 1;
        if (data_o !== 32'd0) begin
            errors = errors + 1;
            $display("FAIL rst_mid_calc_data: data_o=%h expected 00000000", data_o);
        end
        @(negedge clk);
        rst = 1'b0;
        #5000;
        checks = checks + 1;
        if ((done_cnt - base) !== 0) begin
            errors = errors + 1;
            $display("FAIL rst_mid_calc_done: pulses=%0d expected 0", done_cnt - base);
        end
        checks = checks + 1;
        if (data_o !== 32'd0) begin
            errors = errors + 1;
            $display("FAIL rst_mid_calc_hold: data_o=%h expected 00000000", data_o);
        end
    endtask

    task automatic test_restart;
        int base;
        base = done_cnt;
        pulse_start(32'h4080_0000);
        repeat (10) @(posedge clk);
        pulse_start(32'h4110_0000);
        #5000;
        checks = checks + 1;
        if (data_o !== 32'h4040_0000) begin
            errors = errors + 1;
            $display("FAIL restart_data: data_o=%h expected 40400000", data_o);
        end
        checks = checks + 1;
        if ((done_cnt - base) !== 1) begin
            errors = errors + 1;
            $display("FAIL restart_done: pulses=%0d expected 1", done_cnt - base);
        end
    endtask

    task automatic test_back_to_back;
        run_case("b2b_a", 32'h4080_0000, 32'h4000_0000);
        run_case("b2b_b", 32'h4000_0000, 32'h3FB5_04F3);
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        done_cnt = 0;
        rst      = 1'b1;
        start    = 1'b0;
        data_i   = 32'd0;
        test_reset;
        test_normal;
        test_specials;
        test_reset_mid_calc;
        test_restart;
        test_back_to_back;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
